// File: rtl/hub75_pdm_scanner.sv
// HUB75 1/32-scan driver for a 64x64 panel: requests pixels from a painter,
// converts each colour channel to one bit per subframe by PDM, shifts two rows at a time.
//   state     | meaning
//   S_SHIFT   | 64 columns x 4 phases: request, capture, shift out
//   S_BLANK   | LEDs off, row address updated
//   S_LATCH   | latch strobe, LEDs off
//   S_DISPLAY | DELAY cycles lit, then advance row/subframe/frame
module hub75_pdm_scanner #(
    parameter int DELAY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [9:0]  frame,
    output logic [7:0]  subframe,
    output logic [5:0]  x,
    output logic [5:0]  y,
    input  logic [23:0] rgb24,
    output logic [2:0]  rgb0,
    output logic [2:0]  rgb1,
    output logic [4:0]  addr,
    output logic        sclk,
    output logic        lat,
    output logic        oe
);
    typedef enum logic [1:0] {S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    localparam logic [7:0] DELAY_M1 = 8'(DELAY - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_phase;
    logic [5:0] r_col;
    logic [4:0] r_row;
    logic [5:0] r_y;
    logic [7:0] r_subframe;
    logic [9:0] r_frame;
    logic [7:0] r_cnt;
    logic [2:0] r_rgb0;
    logic [2:0] r_rgb1;
    logic [4:0] r_addr;
    logic       r_sclk;
    logic       r_lat;
    logic       r_oe;

    logic [7:0] w_thresh;
    logic [2:0] w_pdm;
    logic [4:0] w_row_inc;
    logic       w_col_end;

    always_comb begin
        w_thresh = '0;
        for (int i = 0; i < 8; i++) begin
            w_thresh[i] = r_subframe[7-i];
        end
    end

    assign w_pdm     = {rgb24[23:16] > w_thresh, rgb24[15:8] > w_thresh, rgb24[7:0] > w_thresh};
    assign w_row_inc = r_row + 5'd1;
    assign w_col_end = (r_phase == 2'd3) && (r_col == 6'd63);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SHIFT:   if (w_col_end) w_state_nxt = S_BLANK;
            S_BLANK:   w_state_nxt = S_LATCH;
            S_LATCH:   w_state_nxt = S_DISPLAY;
            S_DISPLAY: if (r_cnt == 8'd0) w_state_nxt = S_SHIFT;
            default:   w_state_nxt = S_SHIFT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_SHIFT;
            r_phase    <= 2'd0;
            r_col      <= 6'd0;
            r_row      <= 5'd0;
            r_y        <= 6'd0;
            r_subframe <= 8'd0;
            r_frame    <= 10'd0;
            r_cnt      <= 8'd0;
            r_rgb0     <= 3'd0;
            r_rgb1     <= 3'd0;
            r_addr     <= 5'd0;
            r_sclk     <= 1'b0;
            r_lat      <= 1'b0;
            r_oe       <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sclk  <= (r_state == S_SHIFT) && (r_phase == 2'd2);
            r_lat   <= (w_state_nxt == S_LATCH);
            r_oe    <= (w_state_nxt == S_BLANK) || (w_state_nxt == S_LATCH);
            case (r_state)
                S_SHIFT: begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: r_y <= {1'b1, r_row};
                        2'd1: r_rgb0 <= w_pdm;
                        2'd2: r_rgb1 <= w_pdm;
                        default: begin
                            r_col <= r_col + 6'd1;
                            r_y   <= {1'b0, r_row};
                        end
                    endcase
                end
                S_BLANK: r_addr <= r_row;
                S_LATCH: r_cnt <= DELAY_M1;
                default: begin
                    if (r_cnt == 8'd0) begin
                        r_row <= w_row_inc;
                        r_y   <= {1'b0, w_row_inc};
                        if (r_row == 5'd31) begin
                            r_subframe <= r_subframe + 8'd1;
                            if (r_subframe == 8'd255) r_frame <= r_frame + 10'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    assign frame    = r_frame;
    assign subframe = r_subframe;
    assign x        = r_col;
    assign y        = r_y;
    assign rgb0     = r_rgb0;
    // Lower-half pixel arrives during ph2, so it is passed straight through then and held afterwards.
    assign rgb1     = ((r_state == S_SHIFT) && (r_phase == 2'd2)) ? w_pdm : r_rgb1;
    assign addr     = r_addr;
    assign sclk     = r_sclk;
    assign lat      = r_lat;
    assign oe       = r_oe;
endmodule

// File: tb/tb_hub75_pdm_scanner.sv
// Self-checking bench for hub75_pdm_scanner: timing, PDM vectors, counter wraps,
// mid-row reset and panel protocol properties.
module tb_hub75_pdm_scanner;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [23:0] rgb24 = '0;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic [4:0]  addr;
    logic        sclk;
    logic        lat;
    logic        oe;

    hub75_pdm_scanner #(.DELAY(2)) dut (
        .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe),
        .x(x), .y(y), .rgb24(rgb24), .rgb0(rgb0), .rgb1(rgb1),
        .addr(addr), .sclk(sclk), .lat(lat), .oe(oe)
    );

    always #5 clk = ~clk;

    logic        mode = 1'b0;
    logic [23:0] const_rgb = '0;
    always @(posedge clk) rgb24 <= mode ? const_rgb : {16'h0, 2'b00, y};

    typedef struct {
        logic [7:0]  sf;
        logic [23:0] rgb;
        logic [2:0]  exp;
    } vec_t;
    vec_t vecs[8];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_lat = -1;
    int rises    = 0;
    int exp_row  = 0;
    int n_lat    = 0;
    bit mon_en   = 1'b0;
    logic       p_sclk = 1'b0;
    logic [2:0] p_rgb0 = '0;
    logic [2:0] p_rgb1 = '0;
    logic [7:0] f_sf;
    logic [9:0] f_frame;
    int cnt_b, cnt_g, cnt_r;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (sclk && !p_sclk) begin
                chk("rgb0_hold_at_sclk_rise", rgb0, p_rgb0);
                chk("rgb1_hold_at_sclk_rise", rgb1, p_rgb1);
                rises++;
            end
            if (lat) begin
                chk("oe_high_during_lat", oe, 1);
                chk("no_sclk_during_lat", sclk, 0);
                chk("sclk_rises_per_row", rises, 64);
                rises = 0;
                if (last_lat < 0) chk("first_lat_cycle", cyc, 257);
                else chk("lat_spacing", cyc - last_lat, 260);
                last_lat = cyc;
                chk("addr_at_lat", addr, exp_row);
                exp_row = (exp_row + 1) % 32;
                n_lat++;
            end
        end
        p_sclk = sclk;
        p_rgb0 = rgb0;
        p_rgb1 = rgb1;
    endtask

    task automatic wait_lat(input string nm);
        int k;
        k = 0;
        while (!lat && k < 300) begin
            tick();
            k++;
        end
        chk(nm, lat, 1);
    endtask

    task automatic wait_ph3();
        int k;
        repeat (4) tick();
        k = 0;
        while (!sclk && k < 20) begin
            tick();
            k++;
        end
        chk("ph3_reached", sclk, 1);
    endtask

    initial begin
        vecs[0] = '{8'h00, 24'h010000, 3'b100};
        vecs[1] = '{8'h01, 24'h81807F, 3'b100};
        vecs[2] = '{8'h02, 24'h4041FF, 3'b011};
        vecs[3] = '{8'h03, 24'hC0C800, 3'b010};
        vecs[4] = '{8'h80, 24'h020100, 3'b100};
        vecs[5] = '{8'hFF, 24'hFFFFFF, 3'b000};
        vecs[6] = '{8'h0F, 24'hF0F1F0, 3'b010};
        vecs[7] = '{8'h5A, 24'h5B5A59, 3'b100};

        repeat (3) @(negedge clk);
        chk("rst_frame", frame, 0);
        chk("rst_subframe", subframe, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_rgb0", rgb0, 0);
        chk("rst_rgb1", rgb1, 0);
        chk("rst_addr", addr, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_lat", lat, 0);
        chk("rst_oe", oe, 1);

        resetn = 1'b1;
        cyc = 0;
        chk("c0_x", x, 0);
        chk("c0_y", y, 0);
        mon_en = 1'b1;
        while (cyc < 8325) begin
            tick();
            if (cyc == 1) chk("c1_y_lower", y, 32);
            if (cyc == 2) begin
                chk("c2_rgb0", rgb0, 3'b000);
                chk("c2_rgb1", rgb1, 3'b001);
                chk("c2_sclk", sclk, 0);
            end
            if (cyc == 3) chk("c3_sclk", sclk, 1);
            if (cyc == 4) begin
                chk("c4_x", x, 1);
                chk("c4_y", y, 0);
            end
            if (cyc == 100) chk("c100_oe_shift", oe, 0);
            if (cyc == 256) begin
                chk("c256_addr", addr, 0);
                chk("c256_oe", oe, 1);
                chk("c256_lat", lat, 0);
            end
            if (cyc == 257) chk("c257_lat", lat, 1);
            if (cyc == 258) begin
                chk("c258_oe", oe, 0);
                chk("c258_lat", lat, 0);
            end
            if (cyc == 260) begin
                chk("c260_x", x, 0);
                chk("c260_y", y, 1);
            end
            if (cyc == 8319) chk("c8319_subframe", subframe, 0);
            if (cyc == 8320) chk("c8320_subframe", subframe, 1);
        end
        chk("lat_pulses_32_rows", n_lat, 32);
        mon_en = 1'b0;

        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            const_rgb = vecs[i].rgb;
            f_sf = vecs[i].sf;
            force dut.r_subframe = f_sf;
            wait_ph3();
            chk($sformatf("pdm_vec%0d_rgb0", i), rgb0, vecs[i].exp);
            chk($sformatf("pdm_vec%0d_rgb1", i), rgb1, vecs[i].exp);
        end

        const_rgb = 24'h80FF00;
        cnt_b = 0;
        cnt_g = 0;
        cnt_r = 0;
        for (int s = 0; s < 256; s++) begin
            f_sf = 8'(s);
            force dut.r_subframe = f_sf;
            wait_ph3();
            cnt_b += int'(rgb0[2]);
            cnt_g += int'(rgb0[1]);
            cnt_r += int'(rgb0[0]);
        end
        release dut.r_subframe;
        chk("pdm_count_g_ff", cnt_g, 255);
        chk("pdm_count_b_80", cnt_b, 128);
        chk("pdm_count_r_00", cnt_r, 0);

        for (int t = 0; t < 2; t++) begin
            wait_lat("wrap_lat_seen");
            f_frame = (t == 0) ? 10'd5 : 10'd1023;
            force dut.r_row = 5'd31;
            force dut.r_subframe = 8'd255;
            force dut.r_frame = f_frame;
            tick();
            release dut.r_row;
            release dut.r_subframe;
            release dut.r_frame;
            chk("wrap_pre_subframe", subframe, 255);
            begin
                int k;
                k = 0;
                while (subframe == 8'd255 && k < 10) begin
                    tick();
                    k++;
                end
            end
            chk("wrap_subframe", subframe, 0);
            chk("wrap_frame", frame, (t == 0) ? 6 : 0);
            chk("wrap_row0_y", y, 0);
        end

        wait_lat("pre_reset_lat_seen");
        repeat (166) tick();
        chk("col40_x", x, 40);
        chk("col40_sclk_high", sclk, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_oe", oe, 1);
        chk("async_rst_sclk", sclk, 0);
        chk("async_rst_x", x, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        chk("post_rst_x", x, 0);
        chk("post_rst_y", y, 0);
        last_lat = -1;
        rises = 0;
        exp_row = 0;
        p_sclk = sclk;
        p_rgb0 = rgb0;
        p_rgb1 = rgb1;
        mon_en = 1'b1;
        wait_lat("post_rst_lat_seen");
        chk("post_rst_lat_cycle", cyc, 257);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
